// File: rtl/paddle_ctrl_multi.sv
// paddle_ctrl_multi
//   N-paddle Y-position controller for the Pong datapath. Once per video
//   frame, each paddle channel samples its debounced up/down requests. It
//   moves the paddle and clamps it to the play field. While a direction is
//   held, the paddle speeds up.
//
// Ports
//   i_clk        pixel clock, sole clock
//   i_reset      synchronous active-high reset (dominates i_frame_tick)
//   i_frame_tick one-cycle pulse per frame; inputs are sampled only here
//   i_up         per-paddle move-up request
//   i_down       per-paddle move-down request
//   o_pos        packed paddle-top Y, paddle k at [k*POS_W +: POS_W]
//   o_moving     bit k set iff paddle k's position changed on the last tick
//   i_ball_y     (PADDLE_AI_EN only) ball Y used as the AI tracking target
//   i_ai_mask    (PADDLE_AI_EN only) per-paddle AI takeover enable
//
// Optional feature: define PADDLE_AI_EN to add AI-driven channels.

module paddle_ctrl_multi #(
  parameter int NUM_PADDLES   = 2,
  parameter int POS_W         = 10,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 100,
  parameter int SPEED_MIN     = 1,
  parameter int SPEED_MAX     = 8,
  parameter int ACCEL_FRAMES  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_frame_tick,
  input  logic [NUM_PADDLES-1:0]       i_up,
  input  logic [NUM_PADDLES-1:0]       i_down,
`ifdef PADDLE_AI_EN
  input  logic [POS_W-1:0]             i_ball_y,
  input  logic [NUM_PADDLES-1:0]       i_ai_mask,
`endif
  output logic [NUM_PADDLES*POS_W-1:0] o_pos,
  output logic [NUM_PADDLES-1:0]       o_moving
);

  localparam int SPD_W = $clog2(SPEED_MAX + 1);
  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;

  localparam logic [POS_W:0]   MAX_Y    = (POS_W+1)'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [POS_W-1:0] POS_INIT = POS_W'((SCREEN_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [SPD_W-1:0] SPD_MIN  = SPD_W'(SPEED_MIN);
  localparam logic [SPD_W-1:0] SPD_MAX  = SPD_W'(SPEED_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

`ifdef PADDLE_AI_EN
  localparam logic [POS_W:0] HALF_H  = (POS_W+1)'(PADDLE_HEIGHT / 2);
  localparam logic [POS_W:0] AI_STEP = (POS_W+1)'(SPEED_MIN);

  // Shared by all AI channels: ball Y shifted to the paddle top, clamped to the field.
  logic [POS_W:0] ball_ext;
  logic [POS_W:0] ai_target;
  always_comb begin
    ball_ext  = {1'b0, i_ball_y};
    ai_target = (ball_ext < HALF_H) ? '0 : (ball_ext - HALF_H);
    if (ai_target > MAX_Y) ai_target = MAX_Y;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADDLES; gi++) begin : g_chan
      logic [1:0]       state_reg, state_next;
      logic [POS_W-1:0] pos_reg, pos_next;
      logic [SPD_W-1:0] speed_reg, speed_next;
      logic [CNT_W-1:0] count_reg, count_next;
      logic             moving_reg, moving_next;

      // Button-driven step result
      logic [1:0]       btn_state;
      logic [POS_W-1:0] btn_pos;
      logic [SPD_W-1:0] btn_speed;
      logic [CNT_W-1:0] btn_count;
      logic [SPD_W-1:0] eff_speed;
      logic [CNT_W-1:0] eff_count;
      logic [POS_W:0]   pos_ext, spd_ext, pos_sum, pos_dif;

      always_comb begin
        if (i_up[gi] && !i_down[gi])      btn_state = MOVE_UP;
        else if (i_down[gi] && !i_up[gi]) btn_state = MOVE_DOWN;
        else                              btn_state = IDLE;

        // A new direction (or release) restarts the ramp before this tick's move.
        if (btn_state == IDLE || btn_state != state_reg) begin
          eff_speed = SPD_MIN;
          eff_count = '0;
        end else begin
          eff_speed = speed_reg;
          eff_count = count_reg;
        end

        pos_ext = {1'b0, pos_reg};
        spd_ext = (POS_W+1)'(eff_speed);
        pos_sum = pos_ext + spd_ext;
        pos_dif = pos_ext - spd_ext;

        btn_pos   = pos_reg;
        btn_speed = eff_speed;
        btn_count = eff_count;

        if (btn_state == MOVE_UP) begin
          btn_pos = (pos_ext < spd_ext) ? '0 : pos_dif[POS_W-1:0];
        end else if (btn_state == MOVE_DOWN) begin
          btn_pos = (pos_sum > MAX_Y) ? MAX_Y[POS_W-1:0] : pos_sum[POS_W-1:0];
        end

        // Acceleration keeps running against a wall even though the paddle does not move.
        if (btn_state != IDLE) begin
          if (eff_count == CNT_LAST) begin
            btn_count = '0;
            btn_speed = (eff_speed >= SPD_MAX) ? SPD_MAX : (eff_speed + SPD_W'(1));
          end else begin
            btn_count = eff_count + CNT_W'(1);
          end
        end
      end

`ifdef PADDLE_AI_EN
      logic [POS_W-1:0] ai_pos;
      logic [POS_W:0]   ai_dist;
      logic [POS_W:0]   ai_step;
      always_comb begin
        ai_dist = (pos_ext > ai_target) ? (pos_ext - ai_target) : (ai_target - pos_ext);
        ai_step = (ai_dist < AI_STEP) ? ai_dist : AI_STEP;
        if (pos_ext > ai_target) ai_pos = pos_reg - ai_step[POS_W-1:0];
        else                     ai_pos = pos_reg + ai_step[POS_W-1:0];
      end
`endif

      always_comb begin
        state_next  = state_reg;
        pos_next    = pos_reg;
        speed_next  = speed_reg;
        count_next  = count_reg;
        moving_next = moving_reg;
        if (i_frame_tick) begin
`ifdef PADDLE_AI_EN
          if (i_ai_mask[gi]) begin
            // AI tracking uses a fixed step; the ramp stays parked at its reset values.
            state_next = IDLE;
            pos_next   = ai_pos;
            speed_next = SPD_MIN;
            count_next = '0;
          end else begin
            state_next = btn_state;
            pos_next   = btn_pos;
            speed_next = btn_speed;
            count_next = btn_count;
          end
`else
          state_next = btn_state;
          pos_next   = btn_pos;
          speed_next = btn_speed;
          count_next = btn_count;
`endif
          moving_next = (pos_next != pos_reg);
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          state_reg  <= IDLE;
          pos_reg    <= POS_INIT;
          speed_reg  <= SPD_MIN;
          count_reg  <= '0;
          moving_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          pos_reg    <= pos_next;
          speed_reg  <= speed_next;
          count_reg  <= count_next;
          moving_reg <= moving_next;
        end
      end

      assign o_pos[gi*POS_W +: POS_W] = pos_reg;
      assign o_moving[gi]             = moving_reg;
    end
  endgenerate

endmodule

// File: tb/tb_paddle_ctrl_multi.sv
// tb_paddle_ctrl_multi
//   Directed bench for paddle_ctrl_multi with NUM_PADDLES=2 and default geometry.
//   The expected positions are worked out by hand from the speed ramp:
//   4 frames at each speed 1..7, then speed 8 until the wall.

module tb_paddle_ctrl_multi;

  localparam int NP    = 2;
  localparam int POS_W = 10;

  logic            clk = 1'b0;
  logic            i_reset = 1'b0;
  logic            i_frame_tick = 1'b0;
  logic [NP-1:0]   i_up = '0;
  logic [NP-1:0]   i_down = '0;
`ifdef PADDLE_AI_EN
  logic [POS_W-1:0] i_ball_y = '0;
  logic [NP-1:0]    i_ai_mask = '0;
`endif
  logic [NP*POS_W-1:0] o_pos;
  logic [NP-1:0]       o_moving;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  paddle_ctrl_multi dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_frame_tick (i_frame_tick),
    .i_up         (i_up),
    .i_down       (i_down),
`ifdef PADDLE_AI_EN
    .i_ball_y     (i_ball_y),
    .i_ai_mask    (i_ai_mask),
`endif
    .o_pos        (o_pos),
    .o_moving     (o_moving)
  );

  function automatic logic [31:0] pos_of(input int k);
    return 32'(o_pos[k*POS_W +: POS_W]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Tick presented for one cycle; returns on the following negedge with outputs settled.
  task automatic do_tick();
    @(negedge clk);
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    // 1: reset state, and inputs without a tick change nothing
    do_reset();
    chk("rst_pos0", pos_of(0), 190);
    chk("rst_pos1", pos_of(1), 190);
    chk("rst_moving", 32'(o_moving), 0);
    i_up = '1;
    repeat (5) @(negedge clk);
    chk("notick_pos0", pos_of(0), 190);
    chk("notick_mov", 32'(o_moving), 0);
    i_up = '0;

    // 2: paddle 0 up for 5 ticks, speed 2 on the 5th
    i_up = 2'b01;
    do_tick(); chk("up_t1", pos_of(0), 189);
    chk("up_t1_mov", 32'(o_moving), 1);
    do_tick(); chk("up_t2", pos_of(0), 188);
    do_tick(); chk("up_t3", pos_of(0), 187);
    do_tick(); chk("up_t4", pos_of(0), 186);
    do_tick(); chk("up_t5", pos_of(0), 184);
    chk("up_pos1", pos_of(1), 190);
    i_up = '0;

    // 3: full ramp, paddle 0 down to the bottom wall, paddle 1 up to the top wall
    do_reset();
    i_down = 2'b01;
    i_up   = 2'b10;
    for (int t = 1; t <= 39; t++) begin
      do_tick();
      if (t == 4)  begin chk("ramp4_p0", pos_of(0), 194);  chk("ramp4_p1", pos_of(1), 186); end
      if (t == 8)  begin chk("ramp8_p0", pos_of(0), 202);  chk("ramp8_p1", pos_of(1), 178); end
      if (t == 28) begin chk("ramp28_p0", pos_of(0), 302); chk("ramp28_p1", pos_of(1), 78);  end
      if (t == 37) begin chk("ramp37_p0", pos_of(0), 374); chk("ramp37_p1", pos_of(1), 6);   end
      if (t == 38) begin
        chk("wall_p0", pos_of(0), 380);
        chk("wall_p1", pos_of(1), 0);
        chk("wall_mov", 32'(o_moving), 3);
      end
      if (t == 39) begin
        chk("held_p0", pos_of(0), 380);
        chk("held_p1", pos_of(1), 0);
        chk("held_mov", 32'(o_moving), 0);
      end
    end
    // Reversal restarts at speed 1
    i_up   = 2'b01;
    i_down = 2'b10;
    do_tick();
    chk("rev_p0", pos_of(0), 379);
    chk("rev_p1", pos_of(1), 1);
    chk("rev_mov", 32'(o_moving), 3);

    // 4: paddle 1 at speed 3, both buttons, then down moves by 1
    do_reset();
    i_up   = 2'b10;
    i_down = 2'b00;
    repeat (9) do_tick();
    chk("sp3_p1", pos_of(1), 175);
    i_down = 2'b10;
    do_tick();
    chk("both_p1", pos_of(1), 175);
    chk("both_mov", 32'(o_moving), 0);
    i_up = 2'b00;
    do_tick();
    chk("after_both_p1", pos_of(1), 176);
    chk("after_both_mv", 32'(o_moving), 2);
    chk("indep_p0", pos_of(0), 190);
    i_down = '0;

    // 5: reset on the same cycle as a tick dominates
    i_up = '1;
    do_tick();
    chk("pre_rst_p0", pos_of(0), 189);
    chk("pre_rst_mov", 32'(o_moving), 3);
    @(negedge clk);
    i_reset = 1'b1;
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    i_frame_tick = 1'b0;
    chk("rst_tick_p0", pos_of(0), 190);
    chk("rst_tick_p1", pos_of(1), 190);
    chk("rst_tick_mov", 32'(o_moving), 0);
    i_up = '0;

`ifdef PADDLE_AI_EN
    // 6: paddle 1 tracks ball at y=10 (target 0) one line per tick, ignoring i_up
    i_ai_mask = 2'b10;
    i_ball_y  = 10'd10;
    i_up      = 2'b10;
    do_tick();
    chk("ai_t1", pos_of(1), 189);
    repeat (189) do_tick();
    chk("ai_t190", pos_of(1), 0);
    chk("ai_t190_mov", 32'(o_moving), 2);
    do_tick();
    chk("ai_stop", pos_of(1), 0);
    chk("ai_stop_mov", 32'(o_moving), 0);
    chk("ai_p0", pos_of(0), 190);
    i_ai_mask = '0;
    i_up      = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
